// File: rtl/bf16_pkg.sv
// bf16_pkg
//   Shared constants, field-extract helpers and the S1->S2 payload type for
//   the bf16 align/add pipeline.
//   Optional feature macro: BF16_SPECIAL_BYPASS_EN (adds NaN/Inf flags to the
//   payload).
package bf16_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MAN_W  = 7;
    localparam int unsigned SIG_W  = MAN_W + 2;          // carry + hidden + mantissa
    localparam int unsigned WORD_W = EXP_W + MAN_W + 1;  // packed operand width

    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    function automatic logic f_sign(input logic [WORD_W-1:0] w);
        return w[WORD_W-1];
    endfunction

    function automatic logic [EXP_W-1:0] f_exp(input logic [WORD_W-1:0] w);
        return w[WORD_W-2:MAN_W];
    endfunction

    function automatic logic [MAN_W-1:0] f_man(input logic [WORD_W-1:0] w);
        return w[MAN_W-1:0];
    endfunction

    // Hidden bit is implied by a non-zero exponent.
    function automatic logic [SIG_W-2:0] f_sig(input logic [WORD_W-1:0] w);
        return {(f_exp(w) != '0), f_man(w)};
    endfunction

    typedef struct packed {
        logic [EXP_W-1:0] diff;
        logic             eff_sub;
        logic [SIG_W-2:0] sig_x;
        logic [SIG_W-2:0] sig_y;
        logic [EXP_W-1:0] exp_x;
        logic             sign_x;
`ifdef BF16_SPECIAL_BYPASS_EN
        logic             special;
        logic             special_sign;
`endif
    } s1_payload_t;

endpackage

// File: rtl/bf16_align_shifter.sv
// bf16_align_shifter
//   Purely combinational saturating right shift used to align the smaller
//   significand. Any shift of SIG_W-1 or more yields zero.
//   Ports:
//     sig_in  [SIG_W-2:0]  hidden+mantissa significand of the smaller operand
//     amt     [EXP_W-1:0]  exponent difference
//     sig_out [SIG_W-2:0]  aligned significand, shifted-out bits discarded
module bf16_align_shifter
    import bf16_pkg::*;
(
    input  logic [SIG_W-2:0] sig_in,
    input  logic [EXP_W-1:0] amt,
    output logic [SIG_W-2:0] sig_out
);

    always_comb begin
        sig_out = '0;
        if (amt < EXP_W'(SIG_W - 1)) begin
            sig_out = sig_in >> amt;
        end
    end

endmodule

// File: rtl/bf16_align_add_stage.sv
// bf16_align_add_stage
//   Two-stage pipelined bf16 exponent-align and significand add/subtract.
//   S1 orders the operands by magnitude and registers the exponent difference;
//   S2 aligns the smaller significand and adds/subtracts it.
//   Optional feature macro: BF16_SPECIAL_BYPASS_EN (adds out_special and
//   NaN/Inf handling; otherwise all encodings use the arithmetic path).
//   Ports:
//     clk, rst              rising-edge clock, async active-high reset
//     in_valid / in_ready   operand handshake
//     in_a, in_b            packed bf16 operands {sign, exp, man}
//     out_valid / out_ready result handshake
//     out_sig               {carry, hidden, man} magnitude of the sum
//     out_exp               larger operand exponent (pre-normalisation)
//     out_sign              result sign, 0 for a zero magnitude
//     out_special           (macro only) result is NaN/Inf
//   EXP_W/MAN_W must match the bf16_pkg constants; the payload type is fixed
//   by the package.
module bf16_align_add_stage #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [MAN_W+1:0]       out_sig,
    output logic [EXP_W-1:0]       out_exp,
    output logic                   out_sign
`ifdef BF16_SPECIAL_BYPASS_EN
    ,
    output logic                   out_special
`endif
);
    import bf16_pkg::*;

    logic        v1;
    s1_payload_t s1_q;
    s1_payload_t s1_next;
    logic        s2_load;

    // S2 may take new data when empty or being drained this cycle; S1 may
    // accept when empty or advancing into S2.
    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !v1 || !out_valid || out_ready;

    // ---------------- S1 combinational: order operands by magnitude
    logic             a_ge_b;
    logic [WORD_W-1:0] op_x;
    logic [WORD_W-1:0] op_y;

    always_comb begin
        // On a full {exp, man} tie A stays as X.
        a_ge_b = {f_exp(in_a), f_man(in_a)} >= {f_exp(in_b), f_man(in_b)};
        op_x   = a_ge_b ? in_a : in_b;
        op_y   = a_ge_b ? in_b : in_a;

        s1_next         = '0;
        s1_next.diff    = f_exp(op_x) - f_exp(op_y);
        s1_next.eff_sub = f_sign(in_a) ^ f_sign(in_b);
        s1_next.sig_x   = f_sig(op_x);
        s1_next.sig_y   = f_sig(op_y);
        s1_next.exp_x   = f_exp(op_x);
        s1_next.sign_x  = f_sign(op_x);
    end

`ifdef BF16_SPECIAL_BYPASS_EN
    logic nan_a, nan_b, inf_a, inf_b;
    logic special_c, special_sign_c;

    always_comb begin
        nan_a = (f_exp(in_a) == EXP_MAX) && (f_man(in_a) != '0);
        nan_b = (f_exp(in_b) == EXP_MAX) && (f_man(in_b) != '0);
        inf_a = (f_exp(in_a) == EXP_MAX) && (f_man(in_a) == '0);
        inf_b = (f_exp(in_b) == EXP_MAX) && (f_man(in_b) == '0);
        special_c      = nan_a || nan_b || inf_a || inf_b;
        special_sign_c = 1'b0;
        if (nan_a || nan_b) begin
            special_sign_c = 1'b0;
        end else if (inf_a && inf_b) begin
            // Opposite-signed infinities produce NaN (sign 0).
            special_sign_c = (f_sign(in_a) == f_sign(in_b)) ? f_sign(in_a) : 1'b0;
        end else if (inf_a) begin
            special_sign_c = f_sign(in_a);
        end else if (inf_b) begin
            special_sign_c = f_sign(in_b);
        end
    end
`endif

    // ---------------- S2 combinational: align and add/subtract
    logic [SIG_W-2:0] sig_y_sh;
    logic [SIG_W-1:0] sum_c;
    logic             sign_c;

    bf16_align_shifter u_shifter (
        .sig_in  (s1_q.sig_y),
        .amt     (s1_q.diff),
        .sig_out (sig_y_sh)
    );

    always_comb begin
        // X is the larger magnitude, so the difference is never negative.
        if (s1_q.eff_sub) begin
            sum_c = {1'b0, s1_q.sig_x} - {1'b0, sig_y_sh};
        end else begin
            sum_c = {1'b0, s1_q.sig_x} + {1'b0, sig_y_sh};
        end
        sign_c = (sum_c == '0) ? 1'b0 : s1_q.sign_x;
    end

    // ---------------- Pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1        <= 1'b0;
            s1_q      <= '0;
            out_valid <= 1'b0;
            out_sig   <= '0;
            out_exp   <= '0;
            out_sign  <= 1'b0;
`ifdef BF16_SPECIAL_BYPASS_EN
            out_special <= 1'b0;
`endif
        end else begin
            if (s2_load) begin
                out_valid <= v1;
                if (v1) begin
`ifdef BF16_SPECIAL_BYPASS_EN
                    out_special <= s1_q.special;
                    if (s1_q.special) begin
                        out_sig  <= '0;
                        out_exp  <= EXP_MAX;
                        out_sign <= s1_q.special_sign;
                    end else begin
                        out_sig  <= sum_c;
                        out_exp  <= s1_q.exp_x;
                        out_sign <= sign_c;
                    end
`else
                    out_sig  <= sum_c;
                    out_exp  <= s1_q.exp_x;
                    out_sign <= sign_c;
`endif
                end
            end
            if (in_ready) begin
                v1 <= in_valid;
                if (in_valid) begin
                    s1_q <= s1_next;
`ifdef BF16_SPECIAL_BYPASS_EN
                    s1_q.special      <= special_c;
                    s1_q.special_sign <= special_sign_c;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_bf16_align_add_stage.sv
module tb_bf16_align_add_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [8:0]  out_sig;
    logic [7:0]  out_exp;
    logic        out_sign;
`ifdef BF16_SPECIAL_BYPASS_EN
    logic        out_special;
`endif

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [17:0] exp_q[$];

    bf16_align_add_stage #(.EXP_W(8), .MAN_W(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sig   (out_sig),
        .out_exp   (out_exp),
        .out_sign  (out_sign)
`ifdef BF16_SPECIAL_BYPASS_EN
        ,
        .out_special (out_special)
`endif
    );

    always #5 clk = ~clk;

    // Reference: align the smaller-magnitude value to the larger exponent
    // with integer arithmetic and return {sign, exp, sig}.
    function automatic logic [17:0] ref_model(input logic [15:0] a, input logic [15:0] b);
        int unsigned mag_a, mag_b, ex, ey, sx, sy, d, aligned, total;
        logic [15:0] x, y;
        logic [8:0]  r;
        logic        s;
        mag_a = a[14:0];
        mag_b = b[14:0];
        x = (mag_a >= mag_b) ? a : b;
        y = (mag_a >= mag_b) ? b : a;
        ex = x[14:7];
        ey = y[14:7];
        sx = ((ex != 0) ? 128 : 0) + x[6:0];
        sy = ((ey != 0) ? 128 : 0) + y[6:0];
        d = ex - ey;
        aligned = (d >= 8) ? 0 : (sy / (1 << d));
        total = (a[15] != b[15]) ? (sx - aligned) : (sx + aligned);
        r = 9'(total);
        s = (total == 0) ? 1'b0 : x[15];
        return {s, 8'(ex), r};
    endfunction

    // Scoreboard: samples on the falling edge the handshakes that complete on
    // the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL scoreboard_unexpected: got sign=%0b exp=%h sig=%h, required no output",
                             out_sign, out_exp, out_sig);
                end else begin
                    logic [17:0] e;
                    e = exp_q.pop_front();
                    if ({out_sign, out_exp, out_sig} !== e) begin
                        miscompares++;
                        $display("FAIL scoreboard_result: got sign=%0b exp=%h sig=%h, required sign=%0b exp=%h sig=%h",
                                 out_sign, out_exp, out_sig, e[17], e[16:9], e[8:0]);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_model(in_a, in_b));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one pair and returns 1ns after the edge on which it transferred.
    task automatic send_pair(input logic [15:0] a, input logic [15:0] b);
        bit done;
        done = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            step();
        end
        in_valid = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: in_ready never rose for %h + %h", a, b);
        end
    endtask

    task automatic drain();
        int unsigned n;
        out_ready = 1'b1;
        in_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b0;
        repeat (2) step();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b required 0", out_valid); end
        vectors++;
        if (out_sig !== 9'h0) begin miscompares++; $display("FAIL reset_sig: got %h required 000", out_sig); end
        vectors++;
        if (out_exp !== 8'h0) begin miscompares++; $display("FAIL reset_exp: got %h required 00", out_exp); end
        vectors++;
        if (out_sign !== 1'b0) begin miscompares++; $display("FAIL reset_sign: got %b required 0", out_sign); end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        step();
    endtask

    task automatic test_directed();
        logic [15:0] va[7] = '{16'h3F80, 16'h3F80, 16'hBF00, 16'h4000, 16'h4780, 16'h0000, 16'h8000};
        logic [15:0] vb[7] = '{16'h3F80, 16'hBF00, 16'h3F80, 16'hC000, 16'h3F80, 16'h0000, 16'h0000};
        logic [8:0]  es[7] = '{9'h100, 9'h040, 9'h040, 9'h000, 9'h080, 9'h000, 9'h000};
        logic [7:0]  ee[7] = '{8'h7F, 8'h7F, 8'h7F, 8'h80, 8'h8F, 8'h00, 8'h00};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send_pair(va[i], vb[i]);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL latency_early[%0d]: out_valid=%b one cycle after accept, required 0", i, out_valid);
            end
            step();
            vectors++;
            if (out_valid !== 1'b1 || out_sig !== es[i] || out_exp !== ee[i] || out_sign !== 1'b0) begin
                miscompares++;
                $display("FAIL directed[%0d] %h+%h: got v=%b sig=%h exp=%h sign=%b, required v=1 sig=%h exp=%h sign=0",
                         i, va[i], vb[i], out_valid, out_sig, out_exp, out_sign, es[i], ee[i]);
            end
        end
        drain();
    endtask

    function automatic logic [15:0] rand_partner(input logic [15:0] a);
        logic [15:0] b;
        b = 16'($urandom);
        case ($urandom_range(0, 4))
            0: ;
            1: b[14:7] = a[14:7];
            2: b[14:7] = a[14:7] + 8'($urandom_range(0, 9));
            3: b = {~a[15], a[14:0]};
            default: b = {b[15], 15'h0};
        endcase
        return b;
    endfunction

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            in_a = 16'($urandom);
            in_b = rand_partner(in_a);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_a = 16'($urandom);
            in_b = rand_partner(in_a);
            in_valid = 1'b1;
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_in_ready[%0d]: got %b required 1", i, in_ready);
            end
            if (i >= 2) begin
                vectors++;
                if (out_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_bubble[%0d]: out_valid=%b required 1", i, out_valid);
                end
            end
            step();
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [15:0] pa[4];
        logic [15:0] pb[4];
        logic [17:0] snap;
        for (int i = 0; i < 4; i++) begin
            pa[i] = 16'($urandom);
            pb[i] = rand_partner(pa[i]);
        end
        out_ready = 1'b0;
        send_pair(pa[0], pb[0]);
        send_pair(pa[1], pb[1]);
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_full: in_ready=%b out_valid=%b, required 0 and 1", in_ready, out_valid);
        end
        snap = {out_sign, out_exp, out_sig};
        in_a = pa[2];
        in_b = pb[2];
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || {out_sign, out_exp, out_sig} !== snap) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: in_ready=%b out_valid=%b data=%h, required 0 1 %h",
                         i, in_ready, out_valid, {out_sign, out_exp, out_sig}, snap);
            end
            step();
        end
        out_ready = 1'b1;
        send_pair(pa[2], pb[2]);
        send_pair(pa[3], pb[3]);
        drain();
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        send_pair(16'h4000, 16'h3F80);
        send_pair(16'h3F80, 16'hBF00);
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_sig !== 9'h0 || out_exp !== 8'h0) begin
            miscompares++;
            $display("FAIL midreset_clear: v=%b sig=%h exp=%h, required 0 000 00", out_valid, out_sig, out_exp);
        end
        @(negedge clk);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL midreset_stale[%0d]: out_valid=%b required 0", i, out_valid);
            end
        end
        step();
        send_pair(16'h3F80, 16'h3F80);
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_sig !== 9'h100 || out_exp !== 8'h7F || out_sign !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_next: v=%b sig=%h exp=%h sign=%b, required 1 100 7f 0",
                     out_valid, out_sig, out_exp, out_sign);
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
